wb_stage: RTL

Write-back stage of the 5-stage MIPS pipeline, directly upstream of the register file.
- Holds the MEM/WB pipeline register and aligns/extends load data from synchronous data RAM.
- Drives the register-file write port (rfwe/rfwa/rfwd) and owns the HI/LO special registers.
- Exposes its write-back values for forwarding to the decode stage.

---
 rtl/mips_cpu_pkg.sv | 58 +++++
 rtl/load_extract.sv | 40 ++++
 rtl/wb_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the 5-stage MIPS pipeline: data words, GPR names, load kinds
// and the MEM/WB pipeline bundle.
package mips_cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t ZERO = 32'h0000_0000;

  typedef enum logic [4:0] {
    REG_ZERO, REG_AT, REG_V0, REG_V1,
    REG_A0, REG_A1, REG_A2, REG_A3,
    REG_T0, REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
    REG_S0, REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
    REG_T8, REG_T9, REG_K0, REG_K1, REG_GP, REG_SP, REG_FP, REG_RA
  } reg_enum;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } load_enum;

  typedef struct packed {
    logic     valid;
    logic     wreg;
    reg_enum  wa;
    word_t    alu_res;
    load_enum ld_type;
    logic     whilo;
    word_t    hi_n;
    word_t    lo_n;
    logic     first;
  } wb_bus_t;

  localparam wb_bus_t WB_BUS_CLEAR = '{
    valid:   1'b0,
    wreg:    1'b0,
    wa:      REG_ZERO,
    alu_res: ZERO,
    ld_type: LD_NONE,
    whilo:   1'b0,
    hi_n:    ZERO,
    lo_n:    ZERO,
    first:   1'b0
  };

  function automatic word_t ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic word_t ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian byte/half/word selection and extension of a loaded word.
module load_extract
  import mips_cpu_pkg::*;
(
  input  word_t       word,
  input  logic  [1:0] a,
  input  load_enum    ld_type,
  output word_t       result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    unique case (a)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // a[0] is ignored for halfwords; misaligned accesses never reach here
  assign half_sel = a[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = ZERO;
    unique case (ld_type)
      LD_LB:   result = ext8(byte_sel, 1'b1);
      LD_LBU:  result = ext8(byte_sel, 1'b0);
      LD_LH:   result = ext16(half_sel, 1'b1);
      LD_LHU:  result = ext16(half_sel, 1'b0);
      LD_LW:   result = word;
      default: result = ZERO;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load data hold/extract, regfile write
// port and the architectural HI/LO registers.
module wb_stage
  import mips_cpu_pkg::*;
(
  input  logic     cpu_clk_50M,
  input  logic     cpu_rst,
  input  logic     stall,
  input  logic     flush,
  input  logic     mem_valid,
  input  logic     mem_wreg,
  input  reg_enum  mem_wa,
  input  word_t    mem_alu_res,
  input  load_enum mem_ld_type,
  input  logic     mem_whilo,
  input  word_t    mem_hi,
  input  word_t    mem_lo,
  input  word_t    dm_rdata,
  output logic     rfwe,
  output reg_enum  rfwa,
  output word_t    rfwd,
  output word_t    hi,
  output word_t    lo
);

  wb_bus_t wb_d, wb_q;
  word_t   rdata_q;
  word_t   hi_q, lo_q;
  word_t   ld_word;
  word_t   ld_val;
  logic    ld_capture;
  logic    hilo_we;

  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d = WB_BUS_CLEAR;
    end else if (stall) begin
      wb_d.first = 1'b0;
    end else begin
      wb_d.valid   = mem_valid;
      wb_d.wreg    = mem_wreg;
      wb_d.wa      = mem_wa;
      wb_d.alu_res = mem_alu_res;
      wb_d.ld_type = mem_ld_type;
      wb_d.whilo   = mem_whilo;
      wb_d.hi_n    = mem_hi;
      wb_d.lo_n    = mem_lo;
      wb_d.first   = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      wb_q <= WB_BUS_CLEAR;
    end else begin
      wb_q <= wb_d;
    end
  end

  // RAM data is only valid in the first WB cycle; keep a copy for stalls
  assign ld_capture = wb_q.valid & wb_q.first & (wb_q.ld_type != LD_NONE);

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      rdata_q <= ZERO;
    end else if (ld_capture) begin
      rdata_q <= dm_rdata;
    end
  end

  assign hilo_we = wb_q.valid & wb_q.whilo & ~flush;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      hi_q <= ZERO;
      lo_q <= ZERO;
    end else if (hilo_we) begin
      hi_q <= wb_q.hi_n;
      lo_q <= wb_q.lo_n;
    end
  end

  assign ld_word = wb_q.first ? dm_rdata : rdata_q;

  load_extract u_load_extract (
    .word    (ld_word),
    .a       (wb_q.alu_res[1:0]),
    .ld_type (wb_q.ld_type),
    .result  (ld_val)
  );

  always_comb begin
    rfwe = 1'b0;
    rfwa = REG_ZERO;
    rfwd = ZERO;
    if (!cpu_rst) begin
      rfwe = wb_q.valid & wb_q.wreg & (wb_q.wa != REG_ZERO);
      rfwa = wb_q.wa;
      rfwd = (wb_q.ld_type == LD_NONE) ? wb_q.alu_res : ld_val;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
